dispatch_router: RTL
====================

# dispatch_router

Parametrised dispatch stage between rename/decode and the execution ports. It accepts up to FETCH_WIDTH renamed micro-ops per cycle in program order and routes each op to one of NUM_CH issue channels by its class field. It tracks physical-register readiness in an internal scoreboard and issues ready ops per channel, either in order or oldest-ready-first. After a terminator op it holds further dispatch until that terminator has drained.

## Interface
Parameters:
- FETCH_WIDTH, 4, input lanes per cycle
- NUM_CH, 3, issue channels
- DEPTH, 4, entries per channel
- NUM_CMPLT, 6, completion ports
- OOO_MASK, 3'b001, bit c=1: channel c issues oldest-ready; 0: head only
- CLASS_MAP, {2,0,0,0,0,0,1,0} (class 7..0, 2 bits each), channel index per 3-bit class
- TERM_CLASS, 3'b111, class that triggers terminator hold

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all queued ops, clear hold, mark all registers ready
- in_ops  in  FETCH_WIDTH*`RENAMED_OP_SZ  lane i at [i*`RENAMED_OP_SZ +: `RENAMED_OP_SZ]
- in_valid  in  FETCH_WIDTH  per-lane valid
- in_used  out  FETCH_WIDTH  per-lane accept, always a contiguous prefix from lane 0
- cmplt_valid  in  NUM_CMPLT  completion valid
- cmplt_tag  in  NUM_CMPLT*`PR_ADDR_W  completing destination tags
- out_op  out  NUM_CH*`RENAMED_OP_SZ  issued op per channel
- out_valid  out  NUM_CH  issue valid
- out_ready  in  NUM_CH  execution port accepts
- term_hold  out  1  terminator hold active

## Operation
- Op fields (class, dest, src0, src1) are located via package offsets. Tags 0 and 1 are hardwired always-ready and are never marked busy.
- Lane i is accepted when all of the following hold:
  - in_valid[i], and every lane j<i is accepted;
  - no lower lane this cycle targets the same channel (one push per channel per cycle);
  - the target channel's registered count < DEPTH (no same-cycle pop credit);
  - term_hold=0, and no lower lane this cycle is a terminator.
- A terminator lane may itself be accepted; all lanes above it are refused.
- Scoreboard, NREGS bits:
  - Accepting an op with dest ≥2 marks dest busy.
  - A valid cmplt_tag ≥2 marks that tag ready.
  - If allocation and completion hit the same tag in the same cycle, allocation wins.
- Entry source ready bits:
  - At insertion, each source bit = scoreboard ready OR matched by a completion in that cycle (bypass).
  - While queued, a matching completion sets the bit.
  - An entry is ready when both source bits are set.
- Issue:
  - OOO_MASK[c]=1: out_op is the lowest-index (oldest) ready entry.
  - OOO_MASK[c]=0: only entry 0 is issued, and only when it is ready.
  - A pop on out_valid&out_ready removes the entry; higher entries shift down one, preserving age order.
  - A push in the same cycle lands at post-shift count.
- Terminator hold:
  - Set on the edge a TERM_CLASS op is accepted.
  - Cleared on the edge its channel pops its last entry (count goes to 0).
  - Clearing takes effect the following cycle; no same-cycle release.
- Flush: on the next edge, all counts go to 0, the scoreboard becomes all-ready, and term_hold goes to 0. in_used is forced to 0 during the flush cycle.
- rst: same state as flush. After reset, in_used=0 until in_valid is asserted, out_valid=0, and term_hold=0.

## Timing
- An op accepted at edge T can have out_valid in cycle T+1 at the earliest, if its sources are ready.
- A completion at edge T wakes a queued entry, allowing issue in cycle T+1.
- A completion coincident with insertion also allows issue in T+1.
- out_valid/out_op depend only on registered state. in_used depends on in_ops/in_valid and registered state only; there is no combinational path from out_ready or cmplt_* to in_used.
- Full channel: no accept even if that channel pops in the same cycle. Empty channel: out_valid=0.
- Simultaneous push and pop on a full channel does not occur, because the push is refused.

## Structure
- Shared package ooo_defs holds `RENAMED_OP_SZ, `PR_ADDR_W, `PHYS_REGS, OP_CLASS_LSB, OP_DEST_LSB, OP_SRC0_LSB, OP_SRC1_LSB, and the class encodings.
- One sub-module, dispatch_channel, is instantiated NUM_CH times with an OOO parameter. It owns the shift queue, per-entry source ready bits, wakeup matching and issue select.
- Top level holds lane acceptance, the scoreboard and the hold FSM. The hold FSM has two states, RUN and HOLD.

## Test plan
- 4 ALU ops with ready sources (class 0 → channel 0) → in_used=4'b0001 per cycle, since channel 0 takes one push per cycle; each op's out_valid appears the following cycle.
- Lanes classes {0,1,7,0} → in_used=4'b0111 and term_hold=1. Further ops are refused until channel 2 pops its terminator; term_hold=0 in the cycle after that pop.
- Op A writes p5; op B reads p5 (channel 1, in-order) with independent op C queued behind it → C waits. cmplt_tag=5 at edge T → B out_valid at T+1, then C.
- Same dependency pattern in channel 0 (OOO) → C issues first, and B issues after completion of p5.
- Fill channel 1 to DEPTH=4 while holding out_ready=0 → next class-1 lane refused even with out_ready=1 in that cycle; accepted one cycle later.
- Flush with queued entries and term_hold=1 → next cycle out_valid=0, term_hold=0, all scoreboard tags ready.

Source files
------------

// File: rtl/ooo_defs.sv
// Shared renamed-op layout, physical-register sizing and op class encodings
// for the out-of-order front end.
package ooo_defs;

  localparam int PR_ADDR_W     = 6;
  localparam int PHYS_REGS     = 1 << PR_ADDR_W;
  localparam int OP_CLASS_W    = 3;
  localparam int OP_PAY_W      = 8;

  localparam int OP_CLASS_LSB  = 0;
  localparam int OP_DEST_LSB   = OP_CLASS_LSB + OP_CLASS_W;
  localparam int OP_SRC0_LSB   = OP_DEST_LSB + PR_ADDR_W;
  localparam int OP_SRC1_LSB   = OP_SRC0_LSB + PR_ADDR_W;
  localparam int OP_PAY_LSB    = OP_SRC1_LSB + PR_ADDR_W;
  localparam int RENAMED_OP_SZ = OP_PAY_LSB + OP_PAY_W;

  localparam int CH_IDX_W      = 2;

  // Tags below this are hardwired ready and never tracked.
  localparam logic [PR_ADDR_W-1:0] FIRST_REAL_TAG = PR_ADDR_W'(2);

  typedef enum logic [OP_CLASS_W-1:0] {
    CLS_ALU  = 3'd0,
    CLS_MEM  = 3'd1,
    CLS_MUL  = 3'd2,
    CLS_DIV  = 3'd3,
    CLS_BR   = 3'd4,
    CLS_CSR  = 3'd5,
    CLS_FP   = 3'd6,
    CLS_TERM = 3'd7
  } op_class_e;

  typedef enum logic {RUN, HOLD} hold_st_e;

  function automatic logic [OP_CLASS_W-1:0] op_cls(input logic [RENAMED_OP_SZ-1:0] op);
    return op[OP_CLASS_LSB +: OP_CLASS_W];
  endfunction

  function automatic logic [PR_ADDR_W-1:0] op_dest(input logic [RENAMED_OP_SZ-1:0] op);
    return op[OP_DEST_LSB +: PR_ADDR_W];
  endfunction

  function automatic logic [PR_ADDR_W-1:0] op_src0(input logic [RENAMED_OP_SZ-1:0] op);
    return op[OP_SRC0_LSB +: PR_ADDR_W];
  endfunction

  function automatic logic [PR_ADDR_W-1:0] op_src1(input logic [RENAMED_OP_SZ-1:0] op);
    return op[OP_SRC1_LSB +: PR_ADDR_W];
  endfunction

endpackage

// File: rtl/dispatch_channel.sv
// One issue channel: age-ordered shift queue with per-entry source wakeup,
// issuing either the head only or the oldest ready entry.
module dispatch_channel
  import ooo_defs::*;
#(
  parameter int  DEPTH     = 4,
  parameter int  NUM_CMPLT = 6,
  parameter bit  OOO       = 1'b0,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [RENAMED_OP_SZ-1:0]       push_op,
  input  logic                           push_rdy0,
  input  logic                           push_rdy1,
  input  logic [NUM_CMPLT-1:0]           cmplt_valid,
  input  logic [NUM_CMPLT*PR_ADDR_W-1:0] cmplt_tag,
  output logic [RENAMED_OP_SZ-1:0]       out_op,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CNT_W-1:0]               count
);

  logic [DEPTH-1:0][RENAMED_OP_SZ-1:0] q_op, n_op;
  logic [DEPTH-1:0]                    q_r0, q_r1, n_r0, n_r1, wake0, wake1;
  logic [CNT_W-1:0]                    cnt, n_cnt;
  logic                                byp0, byp1, pop;
  logic [IDX_W-1:0]                    sel;

  always_comb begin
    wake0 = '0;
    wake1 = '0;
    byp0  = 1'b0;
    byp1  = 1'b0;
    for (int k = 0; k < NUM_CMPLT; k++) begin
      if (cmplt_valid[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (op_src0(q_op[i]) == cmplt_tag[k*PR_ADDR_W +: PR_ADDR_W]) wake0[i] = 1'b1;
          if (op_src1(q_op[i]) == cmplt_tag[k*PR_ADDR_W +: PR_ADDR_W]) wake1[i] = 1'b1;
        end
        if (op_src0(push_op) == cmplt_tag[k*PR_ADDR_W +: PR_ADDR_W]) byp0 = 1'b1;
        if (op_src1(push_op) == cmplt_tag[k*PR_ADDR_W +: PR_ADDR_W]) byp1 = 1'b1;
      end
    end
  end

  // Issue select looks at registered ready bits only; wakeups show up next cycle.
  always_comb begin
    out_valid = 1'b0;
    sel       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!out_valid && (CNT_W'(i) < cnt) && q_r0[i] && q_r1[i] && (OOO || i == 0)) begin
        out_valid = 1'b1;
        sel       = IDX_W'(i);
      end
    end
  end

  assign out_op = q_op[sel];
  assign pop    = out_valid & out_ready;
  assign count  = cnt;

  always_comb begin
    n_op  = q_op;
    n_r0  = q_r0 | wake0;
    n_r1  = q_r1 | wake1;
    n_cnt = cnt;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(sel)) begin
          n_op[i] = n_op[i+1];
          n_r0[i] = n_r0[i+1];
          n_r1[i] = n_r1[i+1];
        end
      end
      n_cnt = cnt - CNT_W'(1);
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == n_cnt) begin
          n_op[i] = push_op;
          n_r0[i] = push_rdy0 | byp0;
          n_r1[i] = push_rdy1 | byp1;
        end
      end
      n_cnt = n_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      q_r0 <= '0;
      q_r1 <= '0;
    end else begin
      cnt  <= n_cnt;
      q_op <= n_op;
      q_r0 <= n_r0;
      q_r1 <= n_r1;
    end
  end

endmodule

// File: rtl/dispatch_router.sv
// Dispatch stage: in-order lane acceptance, register scoreboard and
// terminator hold, feeding NUM_CH issue channels.
module dispatch_router
  import ooo_defs::*;
#(
  parameter int                      FETCH_WIDTH = 4,
  parameter int                      NUM_CH      = 3,
  parameter int                      DEPTH       = 4,
  parameter int                      NUM_CMPLT   = 6,
  parameter logic [NUM_CH-1:0]       OOO_MASK    = 3'b001,
  parameter logic [8*CH_IDX_W-1:0]   CLASS_MAP   = 16'h8004,
  parameter logic [OP_CLASS_W-1:0]   TERM_CLASS  = 3'b111
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [FETCH_WIDTH*RENAMED_OP_SZ-1:0] in_ops,
  input  logic [FETCH_WIDTH-1:0]           in_valid,
  output logic [FETCH_WIDTH-1:0]           in_used,
  input  logic [NUM_CMPLT-1:0]             cmplt_valid,
  input  logic [NUM_CMPLT*PR_ADDR_W-1:0]   cmplt_tag,
  output logic [NUM_CH*RENAMED_OP_SZ-1:0]  out_op,
  output logic [NUM_CH-1:0]                out_valid,
  input  logic [NUM_CH-1:0]                out_ready,
  output logic                             term_hold
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SZ    = RENAMED_OP_SZ;

  logic                                 clr;
  logic [NUM_CH-1:0][CNT_W-1:0]         ch_cnt;
  logic [NUM_CH-1:0]                    push, push_rdy0, push_rdy1, ch_taken;
  logic [NUM_CH-1:0][SZ-1:0]            push_op;
  logic [FETCH_WIDTH-1:0][SZ-1:0]       lane_op;
  logic [FETCH_WIDTH-1:0][CH_IDX_W-1:0] lane_ch;
  logic [FETCH_WIDTH-1:0]               lane_rdy0, lane_rdy1;
  logic [PHYS_REGS-1:0]                 busy, busy_n;
  logic                                 stop, term_acc;
  logic [CH_IDX_W-1:0]                  term_acc_ch, term_ch;
  hold_st_e                             st;

  assign clr = rst | flush;

  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
    assign lane_op[i] = in_ops[i*SZ +: SZ];
    assign lane_ch[i] = CLASS_MAP[op_cls(lane_op[i])*CH_IDX_W +: CH_IDX_W];
  end

  // Counts are registered, so a pop in this cycle never frees a slot for a push.
  always_comb begin
    in_used     = '0;
    ch_taken    = '0;
    stop        = term_hold | clr;
    term_acc    = 1'b0;
    term_acc_ch = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!stop && in_valid[i] && int'(lane_ch[i]) < NUM_CH && !ch_taken[lane_ch[i]] &&
          ch_cnt[lane_ch[i]] < CNT_W'(DEPTH)) begin
        in_used[i]           = 1'b1;
        ch_taken[lane_ch[i]] = 1'b1;
        if (op_cls(lane_op[i]) == TERM_CLASS) begin
          stop        = 1'b1;
          term_acc    = 1'b1;
          term_acc_ch = lane_ch[i];
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

  // An older lane in the same group writing a source makes that source not ready.
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_rdy0[i] = !busy[op_src0(lane_op[i])];
      lane_rdy1[i] = !busy[op_src1(lane_op[i])];
      for (int j = 0; j < i; j++) begin
        if (in_used[j] && op_dest(lane_op[j]) >= FIRST_REAL_TAG) begin
          if (op_dest(lane_op[j]) == op_src0(lane_op[i])) lane_rdy0[i] = 1'b0;
          if (op_dest(lane_op[j]) == op_src1(lane_op[i])) lane_rdy1[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    push      = '0;
    push_op   = '0;
    push_rdy0 = '0;
    push_rdy1 = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (in_used[i] && int'(lane_ch[i]) == c) begin
          push[c]      = 1'b1;
          push_op[c]   = lane_op[i];
          push_rdy0[c] = lane_rdy0[i];
          push_rdy1[c] = lane_rdy1[i];
        end
      end
    end
  end

  // Allocation is applied after completion so it wins on a shared tag.
  always_comb begin
    busy_n = busy;
    for (int k = 0; k < NUM_CMPLT; k++) begin
      if (cmplt_valid[k] && cmplt_tag[k*PR_ADDR_W +: PR_ADDR_W] >= FIRST_REAL_TAG)
        busy_n[cmplt_tag[k*PR_ADDR_W +: PR_ADDR_W]] = 1'b0;
    end
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (in_used[i] && op_dest(lane_op[i]) >= FIRST_REAL_TAG)
        busy_n[op_dest(lane_op[i])] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) busy <= '0;
    else     busy <= busy_n;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      st        <= RUN;
      term_hold <= 1'b0;
      term_ch   <= '0;
    end else begin
      case (st)
        RUN: if (term_acc) begin
          st        <= HOLD;
          term_hold <= 1'b1;
          term_ch   <= term_acc_ch;
        end
        HOLD: if (out_valid[term_ch] && out_ready[term_ch] && ch_cnt[term_ch] == CNT_W'(1)) begin
          st        <= RUN;
          term_hold <= 1'b0;
        end
        default: st <= RUN;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    dispatch_channel #(
      .DEPTH     (DEPTH),
      .NUM_CMPLT (NUM_CMPLT),
      .OOO       (OOO_MASK[c])
    ) u_ch (
      .clk         (clk),
      .rst         (clr),
      .push        (push[c]),
      .push_op     (push_op[c]),
      .push_rdy0   (push_rdy0[c]),
      .push_rdy1   (push_rdy1[c]),
      .cmplt_valid (cmplt_valid),
      .cmplt_tag   (cmplt_tag),
      .out_op      (out_op[c*SZ +: SZ]),
      .out_valid   (out_valid[c]),
      .out_ready   (out_ready[c]),
      .count       (ch_cnt[c])
    );
  end

endmodule
